// File: rtl/pipe_pkg.sv
// ---------------------------------------------------------------------------
// pipe_pkg
// Shared definitions for the valid/allowin pipeline chain (pipe_seg_chain).
//
// Contents
//   PIPE_DATA_W / PIPE_RDC_W / PIPE_EXC_W  default field widths
//   exc_code_e                             architectural exception codes
//   pipe_fields_t                          one stage's fields (default widths)
//   fields_width()                         packed width of a stage's fields
//
// Stage fields are packed MSB->LSB as {data, rdc, rf_we, ex, ex_code}.
// pipe_fields_t uses the same order, so a default-width stage vector can be
// cast straight to the struct when debugging.
// ---------------------------------------------------------------------------
package pipe_pkg;

    localparam int PIPE_DATA_W = 32;
    localparam int PIPE_RDC_W  = 5;
    localparam int PIPE_EXC_W  = 5;

    typedef enum logic [PIPE_EXC_W-1:0] {
        EXC_INT = 5'd0,
        EXC_SYS = 5'd8,
        EXC_BP  = 5'd9,
        EXC_RI  = 5'd10
    } exc_code_e;

    typedef struct packed {
        logic [PIPE_DATA_W-1:0] data;
        logic [PIPE_RDC_W-1:0]  rdc;
        logic                   rf_we;
        logic                   ex;
        logic [PIPE_EXC_W-1:0]  ex_code;
    } pipe_fields_t;

    // Width of one stage's packed fields: data + rdc + rf_we + ex + ex_code.
    function automatic int fields_width(input int data_w, input int rdc_w,
                                        input int exc_w);
        return data_w + rdc_w + exc_w + 2;
    endfunction

endpackage

// File: rtl/pipe_seg_reg.sv
// ---------------------------------------------------------------------------
// pipe_seg_reg
// One stage of the valid/allowin pipeline chain: a valid bit, the stage's
// packed fields, and the stage's allowin / move-out terms.
//
// Ports
//   clk, rst        clock, synchronous active-high reset
//   flush_i         drop this stage's entry (fields are left as they are)
//   load_i          an entry moves into this stage on this edge
//                   (caller only raises it when allowin_o is 1)
//   fields_i        fields of the incoming entry
//   ready_go_i      this stage has finished its work
//   allowin_next_i  the following stage (or the consumer) can take an entry
//   valid_o         stage holds an entry
//   fields_o        stage fields (held while the stage cannot drain)
//   allowin_o       stage can take an entry this cycle
//   move_out_o      stage's entry leaves on this edge
// ---------------------------------------------------------------------------
module pipe_seg_reg
    import pipe_pkg::*;
#(
    parameter int FW = fields_width(PIPE_DATA_W, PIPE_RDC_W, PIPE_EXC_W)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          flush_i,
    input  logic          load_i,
    input  logic [FW-1:0] fields_i,
    input  logic          ready_go_i,
    input  logic          allowin_next_i,
    output logic          valid_o,
    output logic [FW-1:0] fields_o,
    output logic          allowin_o,
    output logic          move_out_o
);

    logic          valid_q;
    logic          valid_d;
    logic [FW-1:0] fields_q;
    logic [FW-1:0] fields_d;

    // An empty stage always accepts; a full one only when its entry is
    // leaving on the same edge.
    assign move_out_o = valid_q & ready_go_i & allowin_next_i;
    assign allowin_o  = ~valid_q | (ready_go_i & allowin_next_i);

    always_comb begin
        valid_d  = valid_q;
        fields_d = fields_q;
        if (flush_i) begin
            valid_d = 1'b0;
        end else if (load_i) begin
            // Refill wins over vacate when both happen on the same edge.
            valid_d  = 1'b1;
            fields_d = fields_i;
        end else if (move_out_o) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q  <= 1'b0;
            fields_q <= '0;
        end else begin
            valid_q  <= valid_d;
            fields_q <= fields_d;
        end
    end

    assign valid_o  = valid_q;
    assign fields_o = fields_q;

endmodule

// File: rtl/pipe_seg_chain.sv
// ---------------------------------------------------------------------------
// pipe_seg_chain
// Parametrised NUM_STAGES-deep valid/allowin pipeline carrying a payload plus
// rdc, rf_we, ex and ex_code per stage. Provides per-stage ready_go stalls,
// a global flush, input blocking while an exception is in flight, and
// per-stage bypass taps for ID-stage forwarding.
//
// Parameters
//   NUM_STAGES (>=1), DATA_W, RDC_W, EXC_W
//
// Ports
//   clk, rst                   clock, synchronous active-high reset
//   flush                      kill every in-flight entry
//   in_valid / in_allowin      upstream handshake
//   in_data, in_rdc, in_rf_we, in_ex, in_ex_code   incoming entry fields
//   ready_go[NUM_STAGES]       per-stage work done (0 stalls that stage)
//   out_valid / out_allowin    downstream handshake
//   out_data, out_rdc, out_rf_we, out_ex, out_ex_code  last-stage fields
//   tap_data, tap_rdc          per-stage payload / rdc, stage 0 in the LSBs
//   tap_rdc_valid              per-stage forwarding-valid (valid&rf_we&~ex&ready_go)
//   occupancy                  registered count of valid stages
//
// Optional build macro PIPE_CHAIN_PERF_EN adds
//   perf_stall_cnt             cycles with in_valid & ~in_allowin
//   perf_bubble_cnt            cycles with ~out_valid & out_allowin
// Both are zeroed by rst only and wrap at 2^32.
//
// Handshake: an entry moves from a producer to a consumer on a rising edge
// exactly when the producer's valid and the consumer's allowin are both 1 in
// the preceding cycle; valid never depends on allowin of the same interface,
// and a producer keeps its fields stable while valid=1 and allowin=0.
// ---------------------------------------------------------------------------
module pipe_seg_chain
    import pipe_pkg::*;
#(
    parameter int NUM_STAGES = 3,
    parameter int DATA_W     = PIPE_DATA_W,
    parameter int RDC_W      = PIPE_RDC_W,
    parameter int EXC_W      = PIPE_EXC_W
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             flush,
    input  logic                             in_valid,
    output logic                             in_allowin,
    input  logic [DATA_W-1:0]                in_data,
    input  logic [RDC_W-1:0]                 in_rdc,
    input  logic                             in_rf_we,
    input  logic                             in_ex,
    input  logic [EXC_W-1:0]                 in_ex_code,
    input  logic [NUM_STAGES-1:0]            ready_go,
    output logic                             out_valid,
    input  logic                             out_allowin,
    output logic [DATA_W-1:0]                out_data,
    output logic [RDC_W-1:0]                 out_rdc,
    output logic                             out_rf_we,
    output logic                             out_ex,
    output logic [EXC_W-1:0]                 out_ex_code,
    output logic [NUM_STAGES*DATA_W-1:0]     tap_data,
    output logic [NUM_STAGES*RDC_W-1:0]      tap_rdc,
    output logic [NUM_STAGES-1:0]            tap_rdc_valid,
    output logic [$clog2(NUM_STAGES+1)-1:0]  occupancy
`ifdef PIPE_CHAIN_PERF_EN
    ,
    output logic [31:0]                      perf_stall_cnt,
    output logic [31:0]                      perf_bubble_cnt
`endif
);

    localparam int FW       = fields_width(DATA_W, RDC_W, EXC_W);
    localparam int OCC_W    = $clog2(NUM_STAGES + 1);
    // Bit positions inside a stage's packed {data, rdc, rf_we, ex, ex_code}.
    localparam int EX_BIT   = EXC_W;
    localparam int WE_BIT   = EXC_W + 1;
    localparam int RDC_LSB  = EXC_W + 2;
    localparam int DATA_LSB = EXC_W + 2 + RDC_W;

    logic [FW-1:0]                  in_fields;
    logic [NUM_STAGES-1:0]          valid;
    logic [NUM_STAGES-1:0]          move;
    logic [NUM_STAGES-1:0]          ex_live;
    logic [NUM_STAGES-1:0][FW-1:0]  fields;
    logic                           accept;
    logic                           retire;
    logic                           ex_pending;
    logic [OCC_W-1:0]               occ_q;
    logic [OCC_W-1:0]               occ_d;

    assign in_fields = {in_data, in_rdc, in_rf_we, in_ex, in_ex_code};

    // ------------------------------------------------------------------
    // Stage instances. allowin is kept as one scalar per generate block
    // (rather than one vector) so the backward allowin chain is a plain
    // sequence of distinct nets.
    // ------------------------------------------------------------------
    for (genvar i = 0; i < NUM_STAGES; i++) begin : g_stage
        logic          allowin_here;
        logic          allowin_next;
        logic          load;
        logic [FW-1:0] src_fields;

        if (i == 0) begin : g_head
            assign load       = accept;
            assign src_fields = in_fields;
        end else begin : g_body
            assign load       = move[i-1];
            assign src_fields = fields[i-1];
        end

        if (i == NUM_STAGES - 1) begin : g_tail
            assign allowin_next = out_allowin;
        end else begin : g_mid
            assign allowin_next = g_stage[i+1].allowin_here;
        end

        pipe_seg_reg #(
            .FW (FW)
        ) u_seg (
            .clk            (clk),
            .rst            (rst),
            .flush_i        (flush),
            .load_i         (load),
            .fields_i       (src_fields),
            .ready_go_i     (ready_go[i]),
            .allowin_next_i (allowin_next),
            .valid_o        (valid[i]),
            .fields_o       (fields[i]),
            .allowin_o      (allowin_here),
            .move_out_o     (move[i])
        );

        assign ex_live[i] = valid[i] & fields[i][EX_BIT];

        // Bypass taps. Forwarding is only offered once the stage has
        // produced its result (ready_go) and the entry will write back.
        assign tap_data[i*DATA_W +: DATA_W] = fields[i][DATA_LSB +: DATA_W];
        assign tap_rdc[i*RDC_W +: RDC_W]    = fields[i][RDC_LSB +: RDC_W];
        assign tap_rdc_valid[i] = valid[i] & fields[i][WE_BIT]
                                & ~fields[i][EX_BIT] & ready_go[i];
    end

    // Once an excepting entry is in flight nothing younger may enter, so the
    // exception reaches the end of the chain with no work queued behind it.
    assign ex_pending = |ex_live;
    assign in_allowin = g_stage[0].allowin_here & ~flush & ~ex_pending;
    assign accept     = in_valid & in_allowin;

    assign out_valid   = valid[NUM_STAGES-1] & ready_go[NUM_STAGES-1];
    assign retire      = move[NUM_STAGES-1];
    assign out_data    = fields[NUM_STAGES-1][DATA_LSB +: DATA_W];
    assign out_rdc     = fields[NUM_STAGES-1][RDC_LSB +: RDC_W];
    assign out_rf_we   = fields[NUM_STAGES-1][WE_BIT];
    assign out_ex      = fields[NUM_STAGES-1][EX_BIT];
    assign out_ex_code = fields[NUM_STAGES-1][EXC_W-1:0];

    // ------------------------------------------------------------------
    // Occupancy: tracked as a counter so it is a clean register output.
    // accept is already masked by flush through in_allowin, and a retire
    // during flush is discarded because the counter is forced to zero.
    // ------------------------------------------------------------------
    always_comb begin
        occ_d = occ_q;
        if (flush) begin
            occ_d = '0;
        end else if (accept & ~retire) begin
            occ_d = occ_q + OCC_W'(1);
        end else if (~accept & retire) begin
            occ_d = occ_q - OCC_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            occ_q <= '0;
        end else begin
            occ_q <= occ_d;
        end
    end

    assign occupancy = occ_q;

`ifdef PIPE_CHAIN_PERF_EN
    // ------------------------------------------------------------------
    // Performance counters; flush deliberately leaves them running.
    // ------------------------------------------------------------------
    logic [31:0] stall_cnt_q;
    logic [31:0] bubble_cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_q  <= '0;
            bubble_cnt_q <= '0;
        end else begin
            if (in_valid & ~in_allowin) begin
                stall_cnt_q <= stall_cnt_q + 32'd1;
            end
            if (~out_valid & out_allowin) begin
                bubble_cnt_q <= bubble_cnt_q + 32'd1;
            end
        end
    end

    assign perf_stall_cnt  = stall_cnt_q;
    assign perf_bubble_cnt = bubble_cnt_q;
`endif

endmodule

// File: tb/tb_pipe_seg_chain.sv
module tb_pipe_seg_chain;
    import pipe_pkg::*;

    localparam int N  = 3;
    localparam int DW = 32;
    localparam int RW = 5;
    localparam int EW = 5;
    localparam int OW = $clog2(N + 1);

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst = 1'b1;
    logic          flush = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_allowin;
    logic [DW-1:0] in_data = '0;
    logic [RW-1:0] in_rdc = '0;
    logic          in_rf_we = 1'b0;
    logic          in_ex = 1'b0;
    logic [EW-1:0] in_ex_code = '0;
    logic [N-1:0]  ready_go = '1;
    logic          out_valid;
    logic          out_allowin = 1'b1;
    logic [DW-1:0] out_data;
    logic [RW-1:0] out_rdc;
    logic          out_rf_we;
    logic          out_ex;
    logic [EW-1:0] out_ex_code;
    logic [N*DW-1:0] tap_data;
    logic [N*RW-1:0] tap_rdc;
    logic [N-1:0]  tap_rdc_valid;
    logic [OW-1:0] occupancy;
`ifdef PIPE_CHAIN_PERF_EN
    logic [31:0]   perf_stall_cnt;
    logic [31:0]   perf_bubble_cnt;
`endif

    pipe_seg_chain #(
        .NUM_STAGES (N),
        .DATA_W     (DW),
        .RDC_W      (RW),
        .EXC_W      (EW)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .flush         (flush),
        .in_valid      (in_valid),
        .in_allowin    (in_allowin),
        .in_data       (in_data),
        .in_rdc        (in_rdc),
        .in_rf_we      (in_rf_we),
        .in_ex         (in_ex),
        .in_ex_code    (in_ex_code),
        .ready_go      (ready_go),
        .out_valid     (out_valid),
        .out_allowin   (out_allowin),
        .out_data      (out_data),
        .out_rdc       (out_rdc),
        .out_rf_we     (out_rf_we),
        .out_ex        (out_ex),
        .out_ex_code   (out_ex_code),
        .tap_data      (tap_data),
        .tap_rdc       (tap_rdc),
        .tap_rdc_valid (tap_rdc_valid),
        .occupancy     (occupancy)
`ifdef PIPE_CHAIN_PERF_EN
        ,
        .perf_stall_cnt  (perf_stall_cnt),
        .perf_bubble_cnt (perf_bubble_cnt)
`endif
    );

    // ---------------- reference model ----------------
    // The chain is modelled as N slots. Each edge, entries are shifted
    // toward the output starting at the last slot, so a slot is free for
    // its predecessor if it was empty or its own entry just left.
    typedef struct {
        logic          v;
        logic [DW-1:0] d;
        logic [RW-1:0] rdc;
        logic          we;
        logic          ex;
        logic [EW-1:0] code;
    } slot_t;

    slot_t         m [N];
    logic [DW-1:0] exp_q[$];
    bit            model_ok = 1'b0;
    int            n_checks = 0;
    int            n_errors = 0;
`ifdef PIPE_CHAIN_PERF_EN
    logic [31:0]   m_stall = '0;
    logic [31:0]   m_bubble = '0;
`endif

    task automatic chk(input string name, input logic [127:0] act,
                       input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // One clock cycle: compare DUT outputs with the model for the inputs
    // currently applied, then advance model and scoreboard over the edge.
    task automatic tick();
        logic          mv [N];
        logic          free;
        logic          any_ex;
        logic          e_ia;
        logic          e_ov;
        int            cnt;
        logic [N*DW-1:0] e_td;
        logic [N*RW-1:0] e_tr;
        logic [N-1:0]  e_tv;
        logic          dut_ret;
        logic [DW-1:0] ret_data;
        logic [DW-1:0] exp_d;

        #1;
        free = out_allowin;
        for (int i = N - 1; i >= 0; i--) begin
            mv[i] = m[i].v && ready_go[i] && free;
            free  = !m[i].v || mv[i];
        end
        any_ex = 1'b0;
        cnt    = 0;
        for (int i = 0; i < N; i++) begin
            if (m[i].v && m[i].ex) any_ex = 1'b1;
            if (m[i].v) cnt++;
            e_td[i*DW +: DW] = m[i].d;
            e_tr[i*RW +: RW] = m[i].rdc;
            e_tv[i] = m[i].v && m[i].we && !m[i].ex && ready_go[i];
        end
        e_ia = free && !flush && !any_ex;
        e_ov = m[N-1].v && ready_go[N-1];

        if (model_ok) begin
            chk("in_allowin", in_allowin, e_ia);
            chk("out_valid", out_valid, e_ov);
            chk("occupancy", occupancy, cnt);
            chk("tap_rdc_valid", tap_rdc_valid, e_tv);
            chk("tap_data", tap_data, e_td);
            chk("tap_rdc", tap_rdc, e_tr);
            if (e_ov) begin
                chk("out_fields", {out_data, out_rdc, out_rf_we, out_ex, out_ex_code},
                    {m[N-1].d, m[N-1].rdc, m[N-1].we, m[N-1].ex, m[N-1].code});
            end
`ifdef PIPE_CHAIN_PERF_EN
            chk("perf_stall_cnt", perf_stall_cnt, m_stall);
            chk("perf_bubble_cnt", perf_bubble_cnt, m_bubble);
`endif
        end
        dut_ret  = out_valid && out_allowin;
        ret_data = out_data;

        @(posedge clk);
        if (rst) begin
            for (int i = 0; i < N; i++) m[i] = '{1'b0, '0, '0, 1'b0, 1'b0, '0};
            exp_q.delete();
`ifdef PIPE_CHAIN_PERF_EN
            m_stall  = '0;
            m_bubble = '0;
`endif
            model_ok = 1'b1;
        end else if (model_ok) begin
`ifdef PIPE_CHAIN_PERF_EN
            if (in_valid && !e_ia) m_stall = m_stall + 32'd1;
            if (!e_ov && out_allowin) m_bubble = m_bubble + 32'd1;
`endif
            if (flush) begin
                for (int i = 0; i < N; i++) m[i].v = 1'b0;
                exp_q.delete();
            end else begin
                if (dut_ret) begin
                    if (exp_q.size() == 0) begin
                        n_checks++;
                        n_errors++;
                        $display("FAIL scoreboard: retired %0h with nothing expected", ret_data);
                    end else begin
                        exp_d = exp_q.pop_front();
                        chk("scoreboard_order", ret_data, exp_d);
                    end
                end
                for (int i = N - 1; i >= 0; i--) begin
                    if (mv[i]) begin
                        if (i < N - 1) m[i+1] = m[i];
                        m[i].v = 1'b0;
                    end
                end
                if (in_valid && e_ia) begin
                    m[0] = '{1'b1, in_data, in_rdc, in_rf_we, in_ex, in_ex_code};
                    exp_q.push_back(in_data);
                end
            end
        end
        #1;
    endtask

    // ---------------- driver tasks ----------------
    task automatic idle_inputs();
        flush = 1'b0; in_valid = 1'b0; in_data = '0; in_rdc = '0;
        in_rf_we = 1'b0; in_ex = 1'b0; in_ex_code = '0;
        ready_go = '1; out_allowin = 1'b1;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic push(input logic [DW-1:0] d);
        in_valid = 1'b1;
        in_data  = d;
        tick();
    endtask

    task automatic chk_reset_state(input string tag);
        #1;
        chk({tag, "_occupancy"}, occupancy, 0);
        chk({tag, "_out_valid"}, out_valid, 0);
        chk({tag, "_in_allowin"}, in_allowin, 1);
        chk({tag, "_tap_rdc_valid"}, tap_rdc_valid, 0);
        chk({tag, "_tap_data"}, tap_data, 0);
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        logic          iv;
        logic [DW-1:0] d;
        logic [N-1:0]  rg;
        logic          oa;
        logic          ov;
        logic [DW-1:0] od;
        logic [OW-1:0] occ;
        logic          ia;
    } vec_t;

    function automatic vec_t mk(input logic iv, input logic [DW-1:0] d,
                                input logic ov, input logic [DW-1:0] od,
                                input int occ, input logic ia);
        vec_t v;
        v.iv = iv; v.d = d; v.rg = '1; v.oa = 1'b1;
        v.ov = ov; v.od = od; v.occ = OW'(occ); v.ia = ia;
        return v;
    endfunction

    vec_t vt [16];
    logic [EW-1:0] codes [4];

    initial begin
        codes[0] = EXC_INT; codes[1] = EXC_SYS; codes[2] = EXC_BP; codes[3] = EXC_RI;

        // Fill 0x11,0x22,0x33 back-to-back: first output three cycles later.
        vt[0]  = mk(1, 32'h11, 0, 0,      0, 1);
        vt[1]  = mk(1, 32'h22, 0, 0,      1, 1);
        vt[2]  = mk(1, 32'h33, 0, 0,      2, 1);
        vt[3]  = mk(0, 0,      1, 32'h11, 3, 1);
        vt[4]  = mk(0, 0,      1, 32'h22, 2, 1);
        vt[5]  = mk(0, 0,      1, 32'h33, 1, 1);
        vt[6]  = mk(0, 0,      0, 0,      0, 1);
        // Refill, drain one, then accept and retire together at occupancy 2.
        vt[7]  = mk(1, 32'h44, 0, 0,      0, 1);
        vt[8]  = mk(1, 32'h55, 0, 0,      1, 1);
        vt[9]  = mk(1, 32'h66, 0, 0,      2, 1);
        vt[10] = mk(0, 0,      1, 32'h44, 3, 1);
        vt[11] = mk(1, 32'h77, 1, 32'h55, 2, 1);
        vt[12] = mk(0, 0,      1, 32'h66, 2, 1);
        vt[13] = mk(0, 0,      0, 0,      1, 1);
        vt[14] = mk(0, 0,      1, 32'h77, 1, 1);
        vt[15] = mk(0, 0,      0, 0,      0, 1);

        do_reset();
        chk_reset_state("reset");

        for (int r = 0; r < 16; r++) begin
            in_valid = vt[r].iv; in_data = vt[r].d;
            ready_go = vt[r].rg; out_allowin = vt[r].oa;
            #1;
            chk($sformatf("vec%0d_out_valid", r), out_valid, vt[r].ov);
            if (vt[r].ov) chk($sformatf("vec%0d_out_data", r), out_data, vt[r].od);
            chk($sformatf("vec%0d_occupancy", r), occupancy, vt[r].occ);
            chk($sformatf("vec%0d_in_allowin", r), in_allowin, vt[r].ia);
            tick();
        end

        // ---- stall of stage 1 with the chain full ----
        do_reset();
        out_allowin = 1'b0;
        push(32'hA1); push(32'hA2); push(32'hA3);
        ready_go = 3'b101; out_allowin = 1'b1; in_data = 32'hB1;
        #1;
        chk("stall_full_occ", occupancy, 3);
        chk("stall_full_in_allowin", in_allowin, 0);
        for (int c = 0; c < 2; c++) begin
            tick();
            chk($sformatf("stall%0d_occ", c), occupancy, 2);
            chk($sformatf("stall%0d_in_allowin", c), in_allowin, 0);
            chk($sformatf("stall%0d_tap0", c), tap_data[DW-1:0], 32'hA3);
            chk($sformatf("stall%0d_tap1", c), tap_data[2*DW-1:DW], 32'hA2);
        end
        in_valid = 1'b0; ready_go = '1;
        for (int c = 0; c < 4; c++) tick();
        chk("stall_drained_queue", exp_q.size(), 0);

        // ---- reset asserted in the middle of a stall ----
        out_allowin = 1'b0;
        push(32'hC1); push(32'hC2); push(32'hC3);
        in_valid = 1'b0; ready_go = 3'b101; out_allowin = 1'b1;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        idle_inputs();
        chk_reset_state("midstall_reset");

        // ---- bypass taps ----
        in_rdc = 5'd5; in_rf_we = 1'b1;
        push(32'h55);
        in_valid = 1'b0;
        tick();
        chk("tap_rdc_valid1", tap_rdc_valid[1], 1);
        chk("tap_rdc1", tap_rdc[2*RW-1:RW], 5);
        for (int c = 0; c < 3; c++) tick();

        do_reset();
        in_rdc = 5'd5; in_rf_we = 1'b1; in_ex = 1'b1; in_ex_code = EXC_SYS;
        push(32'h66);
        in_ex = 1'b0; in_data = 32'h67;
        tick();
        chk("tap_ex_rdc_valid1", tap_rdc_valid[1], 0);
        chk("tap_ex_in_allowin", in_allowin, 0);
        in_valid = 1'b0;
        for (int c = 0; c < 4; c++) tick();

        // ---- flush with a full chain and a pending input ----
        do_reset();
        out_allowin = 1'b0;
        push(32'hD1); push(32'hD2); push(32'hD3);
        out_allowin = 1'b1; flush = 1'b1; in_data = 32'hAA;
        tick();
        flush = 1'b0; in_valid = 1'b0;
        #1;
        chk("flush_occ", occupancy, 0);
        chk("flush_out_valid", out_valid, 0);
        tick();
        chk("flush_no_capture_occ", occupancy, 0);
        chk("flush_no_capture_valid", out_valid, 0);

        // ---- randomized traffic against the model ----
        do_reset();
        for (int c = 0; c < 2000; c++) begin
            in_valid    = ($urandom_range(0, 9) < 7);
            in_data     = $urandom;
            in_rdc      = RW'($urandom_range(0, 31));
            in_rf_we    = $urandom_range(0, 1) == 1;
            in_ex       = ($urandom_range(0, 19) == 0);
            in_ex_code  = codes[$urandom_range(0, 3)];
            for (int s = 0; s < N; s++) ready_go[s] = ($urandom_range(0, 4) != 0);
            out_allowin = ($urandom_range(0, 3) != 0);
            flush       = ($urandom_range(0, 49) == 0);
            tick();
        end
        idle_inputs();
        for (int c = 0; c < 2 * N; c++) tick();
        chk("random_drained_queue", exp_q.size(), 0);

`ifdef PIPE_CHAIN_PERF_EN
        // ---- perf counters: blocked output for 10 cycles ----
        do_reset();
        out_allowin = 1'b0; in_valid = 1'b1;
        for (int c = 0; c < 10; c++) begin
            in_data = DW'(c);
            tick();
        end
        chk("perf_stall_10", perf_stall_cnt, 10 - N);
        chk("perf_bubble_10", perf_bubble_cnt, 0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
